lvds_rx_deser_align: RTL and testbench

Parametrised multi-channel LVDS receive deserializer with per-channel bit-slip and an automatic training-pattern word aligner. Each channel shifts one serial bit per fast clock into a history register. Every deserialization_factor cycles, an internally generated load strobe captures a word through a per-channel slip window. It sits between the LVDS input buffers and the per-lane link logic, and replaces the external-enable deserializer for links that need lane alignment.

---
 rtl/lvds_rx_deser_align.sv | 165 ++++++++++++++++
 tb/tb_lvds_rx_deser_align.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/lvds_rx_deser_align.sv
// Multi-channel LVDS receive deserializer with per-lane bit-slip and an
// automatic training-pattern word aligner, all on the fast serial clock.
module lvds_rx_deser_align #(
  parameter int number_of_channels = 1,
  parameter int deserialization_factor = 4,
  parameter int REGISTER_WIDTH = deserialization_factor * number_of_channels,
  parameter logic [deserialization_factor-1:0] TRAINING_PATTERN = 4'b1000,
  parameter int LOCK_COUNT = 4,
  parameter int SLIP_WAIT = 1
) (
  input  logic                          rx_fastclk,
  input  logic                          rx_reset,
  input  logic [number_of_channels-1:0] rx_in,
  input  logic [number_of_channels-1:0] rx_bitslip,
  input  logic                          rx_align_en,
  output logic [REGISTER_WIDTH-1:0]     rx_out,
  output logic                          rx_out_valid,
  output logic [number_of_channels-1:0] rx_locked,
  output logic [number_of_channels-1:0] rx_align_err
);

  localparam int J  = deserialization_factor;
  localparam int CW = $clog2(J);
  localparam int TW = $clog2(J + 1);
  localparam int MW = 8;
  localparam int WW = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_HOLD,
    S_LOCKED,
    S_FAIL
  } state_t;

  logic [CW-1:0] cnt;
  logic          primed;
  logic          capture;

  // A capture needs a full word in history, hence the primed flag.
  assign capture = primed && (cnt == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge rx_fastclk) begin
    if (rx_reset) begin
      cnt          <= '0;
      primed       <= 1'b0;
      rx_out_valid <= 1'b0;
    end else begin
      cnt          <= (cnt == CW'(J - 1)) ? '0 : cnt + 1'b1;
      rx_out_valid <= capture;
      if (cnt == CW'(J - 1)) primed <= 1'b1;
    end
  end

  for (genvar c = 0; c < number_of_channels; c++) begin : g_lane
    logic [2*J-1:0] hist;
    logic [CW-1:0]  slip;
    logic [CW-1:0]  slip_inc;
    logic           bs_q;
    logic           manual_slip;
    logic           fsm_slip;
    logic [J-1:0]   word;
    logic [J-1:0]   word_q;
    state_t         state, state_nx;
    logic [TW-1:0]  tries, tries_nx;
    logic [MW-1:0]  match, match_nx;
    logic [WW-1:0]  wait_cnt, wait_nx;
    logic           locked_q, locked_nx;
    logic           err_q, err_nx;

    // Larger slip selects older bits; first-received bit lands in the MSB.
    assign word        = hist[slip +: J];
    assign slip_inc    = (slip == CW'(J - 1)) ? '0 : slip + 1'b1;
    assign manual_slip = !rx_align_en && rx_bitslip[c] && !bs_q;

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
      state_nx  = state;
      tries_nx  = tries;
      match_nx  = match;
      wait_nx   = wait_cnt;
      locked_nx = locked_q;
      err_nx    = err_q;
      fsm_slip  = 1'b0;
      if (!rx_align_en) begin
        state_nx  = S_IDLE;
        locked_nx = 1'b0;
        err_nx    = 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            state_nx = S_CHECK;
            tries_nx = '0;
            match_nx = '0;
          end
          S_CHECK: begin
            if (capture) begin
              if (word == TRAINING_PATTERN) begin
                match_nx = match + 1'b1;
                if (match_nx == MW'(LOCK_COUNT)) begin
                  locked_nx = 1'b1;
                  state_nx  = S_LOCKED;
                end
              end else begin
                match_nx = '0;
                fsm_slip = 1'b1;
                tries_nx = tries + 1'b1;
                if (tries_nx == TW'(J)) begin
                  err_nx   = 1'b1;
                  state_nx = S_FAIL;
                end else if (SLIP_WAIT != 0) begin
                  state_nx = S_HOLD;
                  wait_nx  = WW'(SLIP_WAIT);
                end
              end
            end
          end
          S_HOLD: begin
            if (capture) begin
              wait_nx = wait_cnt - 1'b1;
              if (wait_cnt == WW'(1)) state_nx = S_CHECK;
            end
          end
          default: ;
        endcase
      end
    end

    // NOTE: the history register is reset as well, so the first word after
    // reset never carries stale bits from before it.
    always_ff @(posedge rx_fastclk) begin
      if (rx_reset) begin
        hist     <= '0;
        slip     <= '0;
        bs_q     <= 1'b0;
        word_q   <= '0;
        state    <= S_IDLE;
        tries    <= '0;
        match    <= '0;
        wait_cnt <= '0;
        locked_q <= 1'b0;
        err_q    <= 1'b0;
      end else begin
        hist     <= {hist[2*J-2:0], rx_in[c]};
        bs_q     <= rx_bitslip[c];
        state    <= state_nx;
        tries    <= tries_nx;
        match    <= match_nx;
        wait_cnt <= wait_nx;
        locked_q <= locked_nx;
        err_q    <= err_nx;
        if (capture) word_q <= word;
        if (fsm_slip || manual_slip) slip <= slip_inc;
      end
    end

    assign rx_out[c*J +: J] = word_q;
    assign rx_locked[c]     = locked_q;
    assign rx_align_err[c]  = err_q;
  end

endmodule

// File: tb/tb_lvds_rx_deser_align.sv
// Directed bench for lvds_rx_deser_align: J=4, two lanes, pattern 1000,
// LOCK_COUNT=4, SLIP_WAIT=1. Each lane repeats a 4-bit pattern, MSB first.
module tb_lvds_rx_deser_align;

  localparam int NCH = 2;
  localparam int J   = 4;

  logic             rx_fastclk = 1'b0;
  logic             rx_reset   = 1'b1;
  logic [NCH-1:0]   rx_in      = '0;
  logic [NCH-1:0]   rx_bitslip = '0;
  logic             rx_align_en = 1'b0;
  logic [NCH*J-1:0] rx_out;
  logic             rx_out_valid;
  logic [NCH-1:0]   rx_locked;
  logic [NCH-1:0]   rx_align_err;

  int tests = 0;
  int fails = 0;

  logic [J-1:0] pat0 = '0;
  logic [J-1:0] pat1 = '0;
  int           bit_idx = 0;

  typedef struct {
    int         edge_n;
    logic       valid;
    logic [7:0] out;
  } word_vec_t;

  typedef struct {
    int         edge_n;
    logic       valid;
    logic [1:0] locked;
    logic [7:0] out;
  } align_vec_t;

  word_vec_t  t1[9];
  logic [3:0] t2_exp[4];
  align_vec_t t3[7];

  lvds_rx_deser_align #(
    .number_of_channels    (NCH),
    .deserialization_factor(J),
    .TRAINING_PATTERN      (4'b1000),
    .LOCK_COUNT            (4),
    .SLIP_WAIT             (1)
  ) dut (
    .rx_fastclk  (rx_fastclk),
    .rx_reset    (rx_reset),
    .rx_in       (rx_in),
    .rx_bitslip  (rx_bitslip),
    .rx_align_en (rx_align_en),
    .rx_out      (rx_out),
    .rx_out_valid(rx_out_valid),
    .rx_locked   (rx_locked),
    .rx_align_err(rx_align_err)
  );

  always #5 rx_fastclk = ~rx_fastclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive the bit for the coming edge, then sample 1 time unit after it.
  // After reset, bit_idx equals the number of edges since reset release.
  task automatic cycle();
    int b;
    b = J - 1 - (bit_idx % J);
    rx_in = {pat1[b], pat0[b]};
    @(posedge rx_fastclk);
    #1;
    bit_idx++;
  endtask

  task automatic run_to(input int e);
    while (bit_idx < e) cycle();
  endtask

  task automatic do_reset();
    rx_reset = 1'b1;
    cycle();
    rx_reset = 1'b0;
    bit_idx  = 0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rst_out"},    rx_out,       8'h00);
    check({tag, "_rst_valid"},  rx_out_valid, 1'b0);
    check({tag, "_rst_locked"}, rx_locked,    2'b00);
    check({tag, "_rst_err"},    rx_align_err, 2'b00);
  endtask

  task automatic run_align_table(input string tag);
    foreach (t3[i]) begin
      run_to(t3[i].edge_n);
      check($sformatf("%s_e%0d_valid", tag, t3[i].edge_n),  rx_out_valid, t3[i].valid);
      check($sformatf("%s_e%0d_locked", tag, t3[i].edge_n), rx_locked,    t3[i].locked);
      check($sformatf("%s_e%0d_out", tag, t3[i].edge_n),    rx_out,       t3[i].out);
    end
  endtask

  initial begin
    // Lane0 1011, lane1 0101: first word after edge 5, next after edge 9.
    t1[0] = '{1, 1'b0, 8'h00};
    t1[1] = '{2, 1'b0, 8'h00};
    t1[2] = '{3, 1'b0, 8'h00};
    t1[3] = '{4, 1'b0, 8'h00};
    t1[4] = '{5, 1'b1, 8'h5B};
    t1[5] = '{6, 1'b0, 8'h5B};
    t1[6] = '{7, 1'b0, 8'h5B};
    t1[7] = '{8, 1'b0, 8'h5B};
    t1[8] = '{9, 1'b1, 8'h5B};

    // Stream 1100 seen through slips 1, 2, 3 and back to 0.
    t2_exp[0] = 4'b0110;
    t2_exp[1] = 4'b0011;
    t2_exp[2] = 4'b1001;
    t2_exp[3] = 4'b1100;

    // Lane0 1000 locks at slip 0 on capture 4 (edge 17). Lane1 0100 shows
    // 0100, 0010, 0001 at slips 0..2, each slip followed by one hold capture;
    // slip 3 gives 1000 from edge 25 and the fourth match is at edge 41.
    t3[0] = '{5,  1'b1, 2'b00, 8'h48};
    t3[1] = '{9,  1'b1, 2'b00, 8'h28};
    t3[2] = '{16, 1'b0, 2'b00, 8'h28};
    t3[3] = '{17, 1'b1, 2'b01, 8'h18};
    t3[4] = '{25, 1'b1, 2'b01, 8'h88};
    t3[5] = '{40, 1'b0, 2'b01, 8'h88};
    t3[6] = '{41, 1'b1, 2'b11, 8'h88};

    // Plain deserialization and word timing.
    rx_align_en = 1'b0;
    pat0 = 4'b1011;
    pat1 = 4'b0101;
    do_reset();
    check_reset_state("t1");
    foreach (t1[i]) begin
      run_to(t1[i].edge_n);
      check($sformatf("t1_e%0d_valid", t1[i].edge_n), rx_out_valid, t1[i].valid);
      check($sformatf("t1_e%0d_out", t1[i].edge_n),   rx_out,       t1[i].out);
    end

    // Manual bit-slip on lane 0, one rising edge per word.
    pat0 = 4'b1100;
    do_reset();
    run_to(5);
    check("t2_first", rx_out[3:0], 4'b1100);
    foreach (t2_exp[i]) begin
      rx_bitslip[0] = 1'b1;
      cycle();
      rx_bitslip[0] = 1'b0;
      run_to(bit_idx + 3);
      check($sformatf("t2_w%0d_valid", i), rx_out_valid, 1'b1);
      check($sformatf("t2_w%0d_ch0", i),   rx_out[3:0],  t2_exp[i]);
      check($sformatf("t2_w%0d_ch1", i),   rx_out[7:4],  4'b0101);
    end

    // Automatic alignment on both lanes.
    pat0 = 4'b1000;
    pat1 = 4'b0100;
    rx_align_en = 1'b1;
    do_reset();
    run_align_table("t3");

    // Lane 0 never matches: four slips then error, slip back at 0.
    pat0 = 4'b1111;
    pat1 = 4'b1000;
    do_reset();
    run_to(28);
    check("t4_e28_err0", rx_align_err[0], 1'b0);
    run_to(29);
    check("t4_e29_err0",    rx_align_err[0], 1'b1);
    check("t4_e29_locked0", rx_locked[0],    1'b0);
    rx_align_en = 1'b0;
    cycle();
    check("t4_drop_err",    rx_align_err, 2'b00);
    check("t4_drop_locked", rx_locked,    2'b00);
    pat0 = 4'b1000;
    run_to(37);
    check("t4_slip0_valid", rx_out_valid, 1'b1);
    check("t4_slip0_word",  rx_out[3:0],  4'b1000);

    // Reset while lane 1 sits in its post-slip hold; alignment restarts.
    rx_align_en = 1'b1;
    pat0 = 4'b1000;
    pat1 = 4'b0100;
    do_reset();
    run_to(6);
    do_reset();
    check_reset_state("t5");
    run_to(4);
    check("t5_e4_valid", rx_out_valid, 1'b0);
    run_align_table("t5");

    // Manual slip is ignored while aligned; slip survives align_en drop.
    rx_bitslip[0] = 1'b1;
    cycle();
    rx_bitslip[0] = 1'b0;
    run_to(45);
    check("t6_e45_valid",  rx_out_valid, 1'b1);
    check("t6_e45_out",    rx_out,       8'h88);
    check("t6_e45_locked", rx_locked,    2'b11);
    rx_align_en = 1'b0;
    cycle();
    check("t6_drop_locked", rx_locked, 2'b00);
    run_to(49);
    check("t6_e49_valid", rx_out_valid, 1'b1);
    check("t6_e49_out",   rx_out,       8'h88);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
